// File: rtl/neuron_mac.sv
// Streaming signed dot-product accumulator: bias + sum(data*weight) over N_IN beats,
// rounded once and saturated to the BITS-wide QI.FRAC input format of the sigmoid.
module neuron_mac #(
  parameter int BITS  = 16,
  parameter int FRAC  = 8,
  parameter int N_IN  = 8,
  parameter int ACC_W = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic [BITS-1:0] in_weight,
  input  logic [BITS-1:0] in_bias,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_x,
  output logic            out_sat,
  output logic [1:0]      dbg_state
);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. in_ready depends on state only.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (BITS - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) << (BITS - 1));

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_sum, bias_ext, prod_ext, rnd;
  logic signed [2*BITS-1:0] prod;
  logic [CNT_W-1:0]        cnt, cnt_sum;
  logic                    beat, done;
  logic [BITS-1:0]         x_fin;
  logic                    sat_fin;

  assign dbg_state = state;
  assign in_ready  = (state != OUT);
  assign beat      = in_valid && in_ready;

  assign prod     = $signed(in_data) * $signed(in_weight);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(in_bias)) <<< FRAC;
  assign acc_sum  = ((state == IDLE) ? bias_ext : acc) + prod_ext;
  assign cnt_sum  = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  assign done     = (cnt_sum == CNT_W'(N_IN));

  // Single rounding step (half toward +inf) on the final sum, then clamp.
  assign rnd = (acc_sum + HALF) >>> FRAC;

  always_comb begin
    x_fin   = rnd[BITS-1:0];
    sat_fin = 1'b0;
    if (rnd > MAXV) begin
      x_fin   = MAXV[BITS-1:0];
      sat_fin = 1'b1;
    end else if (rnd < MINV) begin
      x_fin   = MINV[BITS-1:0];
      sat_fin = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (beat) state_nxt = done ? OUT : ACCUM;
      OUT:         if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        acc <= acc_sum;
        cnt <= cnt_sum;
        if (done) begin
          out_valid <= 1'b1;
          out_x     <= x_fin;
          out_sat   <= sat_fin;
        end
      end
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac (N_IN=4, Q8.8): directed scenarios plus random vectors,
// scored against an integer-arithmetic reference through an expected queue.
module tb_neuron_mac;

  localparam int BITS = 16;
  localparam int FRAC = 8;
  localparam int N_IN = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_data = '0, in_weight = '0, in_bias = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BITS-1:0] out_x;
  logic            out_sat;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  bit rand_bp = 1'b0;
  logic [BITS:0] exp_q[$];

  neuron_mac #(.BITS(BITS), .FRAC(FRAC), .N_IN(N_IN), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_sat(out_sat), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference: exact integer sum, floor((s + half) / 2^FRAC), clamp
  function automatic logic [BITS:0] model(input logic [BITS-1:0] d[N_IN],
                                          input logic [BITS-1:0] w[N_IN],
                                          input logic [BITS-1:0] b);
    longint s, q;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(d[i])) * longint'($signed(w[i]));
    s = s + 128;
    q = s / 256;
    if ((s % 256) != 0 && s < 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(q)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change at posedge+1
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [BITS-1:0] d, input logic [BITS-1:0] w,
                           input logic [BITS-1:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_weight = w; in_bias = b;
    while (!in_ready && n < 200) begin step(1); n++; end
    if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [BITS-1:0] d[N_IN], input logic [BITS-1:0] w[N_IN],
                          input logic [BITS-1:0] b, input int gap);
    for (int i = 0; i < N_IN; i++) begin
      send_beat(d[i], w[i], b);
      if (i == 1 && gap > 0) step(gap);
    end
    exp_q.push_back(model(d, w, b));
  endtask

  task automatic fill(output logic [BITS-1:0] d[N_IN], output logic [BITS-1:0] w[N_IN],
                      input logic [BITS-1:0] dv, input logic [BITS-1:0] wv);
    for (int i = 0; i < N_IN; i++) begin d[i] = dv; w[i] = wv; end
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(1); n++; end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor: compares whenever a result handshake is about to happen
  always @(negedge clk) begin
    logic [BITS:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {15'd0, out_sat, out_x}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_sat_x", {15'd0, out_sat, out_x}, {15'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [BITS-1:0] d[N_IN], w[N_IN];
    logic [BITS-1:0] held;

    step(2);
    rst = 1'b0;
    step(1);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_x", 32'(out_x), 32'd0);
    check("reset_out_sat", 32'(out_sat), 32'd0);

    // 1: basic, with latency check around the last beat
    fill(d, w, 16'h0100, 16'h0080);
    for (int i = 0; i < N_IN - 1; i++) send_beat(d[i], w[i], 16'h0000);
    check("s1_no_early_valid", 32'(out_valid), 32'd0);
    send_beat(d[N_IN-1], w[N_IN-1], 16'h0000);
    exp_q.push_back({1'b0, 16'h0200});
    check("s1_valid_latency", 32'(out_valid), 32'd1);
    check("s1_in_ready_out", 32'(in_ready), 32'd0);
    drain();

    // 2-4: directed values with hard-coded expectations cross-checked by the model
    fill(d, w, 16'hFF00, 16'h0100);
    check("s2_model", 32'(model(d, w, 16'hFF00)), 32'h0FB00);
    send_vec(d, w, 16'hFF00, 0);
    fill(d, w, 16'h0001, 16'h0080);
    check("s3_model", 32'(model(d, w, 16'h0000)), 32'h00002);
    send_vec(d, w, 16'h0000, 0);
    fill(d, w, 16'h0000, 16'h0000);
    d[0] = 16'h0001; w[0] = 16'h0040;
    check("s3b_model", 32'(model(d, w, 16'h0000)), 32'h00000);
    send_vec(d, w, 16'h0000, 0);
    fill(d, w, 16'h7FFF, 16'h7FFF);
    check("s4_pos_model", 32'(model(d, w, 16'h0000)), 32'h17FFF);
    send_vec(d, w, 16'h0000, 0);
    fill(d, w, 16'h8000, 16'h7FFF);
    check("s4_neg_model", 32'(model(d, w, 16'h0000)), 32'h18000);
    send_vec(d, w, 16'h0000, 0);
    drain();

    // 5: gaps between beats 2 and 3, then a 5-cycle stall with in_valid held high
    out_ready = 1'b0;
    fill(d, w, 16'h0100, 16'h0080);
    send_vec(d, w, 16'h0000, 2);
    held = out_x;
    check("s5_stall_x", 32'(held), 32'h0200);
    in_valid = 1'b1; in_data = 16'h7FFF; in_weight = 16'h7FFF; in_bias = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("s5_stall_in_ready", 32'(in_ready), 32'd0);
      check("s5_stall_stable", {15'd0, out_valid, out_x}, {15'd0, 1'b1, held});
      step(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    check("s5_ready_after_hs", 32'(in_ready), 32'd1);
    check("s5_valid_after_hs", 32'(out_valid), 32'd0);
    drain();

    // 6a: clear after two beats, then scenario 2
    send_beat(16'h0100, 16'h0080, 16'h0000);
    send_beat(16'h0100, 16'h0080, 16'h0000);
    clear = 1'b1; in_valid = 1'b1;
    step(1);
    clear = 1'b0; in_valid = 1'b0;
    check("s6_clear_state", {30'd0, out_valid, in_ready}, 32'd1);
    fill(d, w, 16'hFF00, 16'h0100);
    send_vec(d, w, 16'hFF00, 0);
    drain();

    // 6b: asynchronous reset while a result is held, and mid-vector
    out_ready = 1'b0;
    fill(d, w, 16'h7FFF, 16'h7FFF);
    send_vec(d, w, 16'h0000, 0);
    #3 rst = 1'b1;
    #1;
    check("s6_async_rst_out", {14'd0, out_valid, out_sat, out_x}, 32'd0);
    exp_q.delete();
    step(1);
    rst = 1'b0;
    out_ready = 1'b1;
    send_beat(16'h0100, 16'h0100, 16'h0100);
    send_beat(16'h0100, 16'h0100, 16'h0100);
    #3 rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s6_rst_in_ready", 32'(in_ready), 32'd1);
    fill(d, w, 16'h0100, 16'h0080);
    send_vec(d, w, 16'h0000, 0);
    drain();

    // random vectors with random gaps and random backpressure
    rand_bp = 1'b1;
    for (int v = 0; v < 60; v++) begin
      for (int i = 0; i < N_IN; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          d[i] = 16'($urandom); w[i] = 16'($urandom);
        end else begin
          d[i] = 16'($signed(11'($urandom))); w[i] = 16'($signed(11'($urandom)));
        end
      end
      send_vec(d, w, 16'($urandom), $urandom_range(0, 2));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Streaming dot-product accumulator that computes the pre-activation x = bias + Σ(in_data·in_weight) over N_IN signed fixed-point terms. It sits directly upstream of the piecewise sigmoid: it delivers one saturated BITS-wide x per vector on out_x, which feeds the sigmoid's x input. The block is sequential with valid/ready handshakes on both sides. It uses full-precision accumulation, a single rounding step and saturation to the sigmoid input format.

## Interface
- BITS, 16: data width of inputs, weights, bias and out_x (signed, two's complement).
- FRAC, 8: fractional bits. Q8.8 by default, the same format as the sigmoid input.
- N_IN, 8: terms per dot product, ≥1.
- ACC_W, 40: accumulator width. Must satisfy ACC_W ≥ 2·BITS + clog2(N_IN) + 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous abort. Discards any partial vector and the pending output.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  BITS  activation term, signed QI.FRAC.
- in_weight  in  BITS  weight term, signed QI.FRAC.
- in_bias  in  BITS  bias. Sampled only on the first beat of a vector.
- out_valid  out  1  out_x is valid.
- out_ready  in  1  downstream accepts out_x.
- out_x  out  BITS  rounded, saturated pre-activation, signed QI.FRAC.
- out_sat  out  1  saturation occurred for this out_x.

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready=1.
  - An accepted beat (in_valid&&in_ready) sets acc = (in_bias sign-extended <<FRAC) + in_data·in_weight and cnt=1.
  - The next state is ACCUM, or OUT if N_IN=1.
- ACCUM:
  - in_ready=1.
  - Each accepted beat does acc += in_data·in_weight and cnt++.
  - The beat on which cnt reaches N_IN moves the state to OUT.
  - Cycles without in_valid leave acc and cnt unchanged (gaps allowed).
- Arithmetic:
  - Product is a signed BITS×BITS → 2·BITS bit value in Q(2·FRAC), sign-extended to ACC_W.
  - No intermediate truncation.
- Finalisation (registered on the OUT transition):
  - r = (acc + 2^(FRAC−1)) >>> FRAC, arithmetic shift. This is round-half-toward-+∞.
  - If r > 2^(BITS−1)−1 then out_x=0x7FFF and out_sat=1.
  - If r < −2^(BITS−1) then out_x=0x8000 and out_sat=1.
  - Otherwise out_x=r[BITS−1:0] and out_sat=0.
- OUT:
  - out_valid=1 and in_ready=0.
  - out_x and out_sat are held stable until out_valid&&out_ready.
  - On that handshake the state goes to IDLE. The block never accepts a new beat in the same cycle as the output handshake.
- clear=1:
  - Next state is IDLE, with acc=0, cnt=0, out_valid=0, out_x=0, out_sat=0.
  - clear has priority over a simultaneous input beat or output handshake; the beat is dropped.
- Reset (asynchronous, any state, including mid-vector):
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_x=0, out_sat=0.
  - in_ready=1 once rst deasserts.

## Timing
- Input throughput: one beat per cycle while in_ready=1.
- Latency: out_valid rises on the clock edge that accepts the N_IN-th beat, i.e. it is visible the cycle after that beat.
- Minimum vector period: N_IN + 1 cycles, with out_ready held at 1.
- in_ready is a function of state only. It has no combinational path from out_ready or in_valid.
- out_x, out_sat and out_valid are registered outputs.
- in_bias on non-first beats is ignored.
- A partial vector never times out. It completes only on N_IN beats, clear or rst.

## Test plan
All scenarios use N_IN=4, BITS=16, FRAC=8.

1. **Basic dot product.**
   - Stimulus: 4 beats in_data=0x0100, in_weight=0x0080, in_bias=0x0000.
   - Required: out_x=0x0200, out_sat=0, out_valid one cycle after the 4th beat.
2. **Negative sum with bias.**
   - Stimulus: 4 beats in_data=0xFF00, in_weight=0x0100, in_bias=0xFF00.
   - Required: out_x=0xFB00 (−5.0), out_sat=0.
3. **Rounding.**
   - Stimulus: 4 beats in_data=0x0001, in_weight=0x0080, bias 0.
   - Required: acc=0x200, out_x=0x0002.
   - Also: a single beat in_data=0x0001, in_weight=0x0040 followed by three zero beats gives out_x=0x0000.
4. **Saturation.**
   - Stimulus: 4 beats 0x7FFF×0x7FFF.
   - Required: out_x=0x7FFF, out_sat=1.
   - Stimulus: 4 beats 0x8000×0x7FFF.
   - Required: out_x=0x8000, out_sat=1.
5. **Backpressure and gaps.**
   - Stimulus: insert 2 idle cycles between beats 2 and 3. Then hold out_ready=0 for 5 cycles with in_valid=1.
   - Required: result identical to scenario 1. out_x stable, in_ready=0 and no beat consumed during the stall. in_ready=1 the cycle after the handshake.
6. **Abort and reset.**
   - Stimulus: after 2 beats pulse clear, then send scenario 2.
   - Required: 0xFB00.
   - Stimulus: assert rst mid-vector.
   - Required: all outputs 0 immediately (asynchronously). The next full scenario 1 vector gives 0x0200.
